um_cfg_ctrl: RTL and testbench
==============================

UM_CFG_CTRL -- requirements
Module: um_cfg_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h7000_0000; register window base, register offsets 0x00-0x13.
REQ-002 One clock; reset is synchronous and active-low: clk input 1, rst_n input 1.
REQ-003 dma2um_data input 134: command flit; [133:128] header, [127:120] opcode, [119:96] tag, [95:64] address, [63:0] data.
REQ-004 dma2um_data_wr input 1: flit strobe.
REQ-005 um2dma_ready output 1: block can accept a command flit.
REQ-006 um2dma_data output 134: response flit, same field layout as commands.
REQ-007 um2dma_data_wr output 1: response strobe.
REQ-008 dma2um_ready input 1: response sink can accept.
REQ-009 cfg_protocol_type output 8: configured protocol type.
REQ-010 cfg_stat_reset output 1: one-cycle statistics-clear pulse.
REQ-011 cfg_n_rtt output 32: configured RTT count.
REQ-012 stat_bit_cnt, stat_pkt_cnt, stat_time_cnt: inputs, 64 bits each, live counters.

Function
REQ-013 Flit accepted only when dma2um_data_wr and um2dma_ready are both 1 in the same cycle.
REQ-014 Valid command: header 6'b010000 (single flit). Any other header: flit dropped, no response, drop counter +1.
REQ-015 Opcodes: 0xA0 write, 0xB0 read; any other opcode is an error.
REQ-016 FSM states IDLE, EXEC, RESP.
- IDLE: um2dma_ready=1; on acceptance, latch flit, go EXEC.
- EXEC: um2dma_ready=0. Valid write: go IDLE. Read or error: go RESP.
- RESP: um2dma_ready=0; hold response until dma2um_ready=1, then go IDLE.
REQ-017 Write offsets:
- 0x00: cfg_protocol_type = data[7:0].
- 0x01: data[0]=1 pulses cfg_stat_reset for exactly one cycle.
- 0x02: cfg_n_rtt = data[31:0].
REQ-018 A write in EXEC updates the output register on the clock edge that leaves EXEC, i.e. the new value is visible 2 cycles after acceptance; writes produce no response.
REQ-019 Read offsets:
- 0x00/0x02: zero-extended current config.
- 0x10/0x11/0x12: bit/pkt/time counters.
- 0x13: drop counter zero-extended.
Read value is sampled in EXEC and held stable through RESP.
REQ-020 Read response: header 6'b010000, opcode 0xC0, tag and address echoed, data = read value.
REQ-021 Error (bad opcode, address outside window, write to read-only offset, read of 0x01): opcode 0xE0, tag and address echoed, data 0; no register changes.
REQ-022 um2dma_data_wr is 1 for exactly one cycle, the cycle in RESP with dma2um_ready=1. um2dma_data holds stable from RESP entry until that cycle.
REQ-023 Minimum read latency: acceptance at cycle N gives the response strobe at N+2 when dma2um_ready=1. Command throughput: at most one command per 2 cycles (writes), 3 cycles (reads).
REQ-024 Drop counter: 16 bits, saturates at 0xFFFF, cleared only by reset.
REQ-025 Flits arriving while um2dma_ready=0 are ignored and not counted.

Reset
REQ-026 While rst_n=0 at a clock edge:
- FSM goes to IDLE.
- cfg_protocol_type=0, cfg_n_rtt=0, cfg_stat_reset=0.
- um2dma_data_wr=0, um2dma_data=0.
- Drop counter=0.
- um2dma_ready=0.
REQ-027 um2dma_ready=1 from the first cycle after rst_n returns to 1.
REQ-028 Reset during EXEC or RESP discards the pending write or response; no strobe is emitted afterwards.

Verification
REQ-029 Write 0x70000000 with data 0x82 -> cfg_protocol_type=0x82 two cycles after acceptance, no um2dma_data_wr.
REQ-030 Write 0x70000002 with data 0x30, then read 0x70000002 with tag 0x008007 -> response opcode 0xC0, tag 0x008007, data 0x30.
REQ-031 Write 0x70000001 with data 1 -> cfg_stat_reset high for exactly one cycle. Data 0 -> no pulse.
REQ-032 Read 0x70000011 with dma2um_ready held 0 for 5 cycles -> um2dma_data stable, um2dma_ready=0 throughout, single strobe when ready rises.
REQ-033 Header 6'b100000 flit, then read 0x70000013 -> data 1. Opcode 0x55 -> response opcode 0xE0, data 0.
REQ-034 Reset asserted in RESP -> no strobe, all config outputs 0, um2dma_ready=1 the cycle after release.

Source files
------------

// File: rtl/um_cfg_ctrl.sv
// um_cfg_ctrl: single-flit command endpoint for the configuration/statistics
// register window. Accepts write/read commands, updates the config registers
// and returns read/error response flits with back-pressure from the sink.
module um_cfg_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h7000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] dma2um_data,
  input  logic         dma2um_data_wr,
  output logic         um2dma_ready,
  output logic [133:0] um2dma_data,
  output logic         um2dma_data_wr,
  input  logic         dma2um_ready,
  output logic [7:0]   cfg_protocol_type,
  output logic         cfg_stat_reset,
  output logic [31:0]  cfg_n_rtt,
  input  logic [63:0]  stat_bit_cnt,
  input  logic [63:0]  stat_pkt_cnt,
  input  logic [63:0]  stat_time_cnt
);

  localparam logic [5:0] HDR_CMD = 6'b010000;
  localparam logic [7:0] OP_WR   = 8'hA0;
  localparam logic [7:0] OP_RD   = 8'hB0;
  localparam logic [7:0] OP_RSP  = 8'hC0;
  localparam logic [7:0] OP_ERR  = 8'hE0;
  localparam logic [31:0] WIN_SIZE = 32'h0000_0014;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Saturating increment used by the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc16 = v;
    end else begin
      sat_inc16 = v + 16'd1;
    end
  endfunction

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  // Latched command: opcode, tag, address and the low data word (the only
  // data bits any register consumes).
  logic [95:0]   cmd_q, cmd_d;
  logic [133:0]  resp_q, resp_d;
  logic [7:0]    ptype_q, ptype_d;
  logic [31:0]   rtt_q, rtt_d;
  logic          stat_rst_q, stat_rst_d;
  logic [15:0]   drop_q, drop_d;

  logic [7:0]    cmd_op_s;
  logic [23:0]   cmd_tag_s;
  logic [31:0]   cmd_addr_s;
  logic [31:0]   cmd_data_s;
  logic [31:0]   offset_s;
  logic          in_win_s;
  logic          is_wr_s;
  logic          is_rd_s;
  logic          wr_ok_s;
  logic          rd_ok_s;
  logic [63:0]   rd_val_s;
  logic          unused_ok_s;

  assign cmd_op_s   = cmd_q[95:88];
  assign cmd_tag_s  = cmd_q[87:64];
  assign cmd_addr_s = cmd_q[63:32];
  assign cmd_data_s = cmd_q[31:0];

  // Offset wraps to a large value for addresses below the base, so a single
  // unsigned compare covers both window edges.
  assign offset_s = cmd_addr_s - BASE_ADDR;
  assign in_win_s = (offset_s < WIN_SIZE);
  assign is_wr_s  = (cmd_op_s == OP_WR);
  assign is_rd_s  = (cmd_op_s == OP_RD);

  // Upper command data bits carry no register content.
  assign unused_ok_s = ^dma2um_data[63:32];

  // Classify the latched command and select the read source for its offset.
  always_comb begin
    wr_ok_s  = 1'b0;
    rd_ok_s  = 1'b0;
    rd_val_s = 64'd0;
    if (in_win_s) begin
      case (offset_s[4:0])
        5'h00: begin
          wr_ok_s  = is_wr_s;
          rd_ok_s  = is_rd_s;
          rd_val_s = {56'd0, ptype_q};
        end
        5'h01: begin
          wr_ok_s  = is_wr_s;
          rd_ok_s  = 1'b0;
          rd_val_s = 64'd0;
        end
        5'h02: begin
          wr_ok_s  = is_wr_s;
          rd_ok_s  = is_rd_s;
          rd_val_s = {32'd0, rtt_q};
        end
        5'h10: begin
          wr_ok_s  = 1'b0;
          rd_ok_s  = is_rd_s;
          rd_val_s = stat_bit_cnt;
        end
        5'h11: begin
          wr_ok_s  = 1'b0;
          rd_ok_s  = is_rd_s;
          rd_val_s = stat_pkt_cnt;
        end
        5'h12: begin
          wr_ok_s  = 1'b0;
          rd_ok_s  = is_rd_s;
          rd_val_s = stat_time_cnt;
        end
        5'h13: begin
          wr_ok_s  = 1'b0;
          rd_ok_s  = is_rd_s;
          rd_val_s = {48'd0, drop_q};
        end
        default: begin
          wr_ok_s  = 1'b0;
          rd_ok_s  = 1'b0;
          rd_val_s = 64'd0;
        end
      endcase
    end else begin
      wr_ok_s  = 1'b0;
      rd_ok_s  = 1'b0;
      rd_val_s = 64'd0;
    end
  end

  // Next-state logic: accept/drop in IDLE, execute in EXEC, hand off in RESP.
  always_comb begin
    state_d    = state_q;
    ready_d    = 1'b0;
    cmd_d      = cmd_q;
    resp_d     = resp_q;
    ptype_d    = ptype_q;
    rtt_d      = rtt_q;
    stat_rst_d = 1'b0;
    drop_d     = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (dma2um_data_wr && ready_q) begin
          if (dma2um_data[133:128] == HDR_CMD) begin
            cmd_d   = {dma2um_data[127:64], dma2um_data[31:0]};
            state_d = ST_EXEC;
          end else begin
            drop_d  = sat_inc16(drop_q);
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (wr_ok_s) begin
          state_d = ST_IDLE;
          case (offset_s[4:0])
            5'h00:   ptype_d    = cmd_data_s[7:0];
            5'h01:   stat_rst_d = cmd_data_s[0];
            5'h02:   rtt_d      = cmd_data_s;
            default: ptype_d    = ptype_q;
          endcase
        end else if (rd_ok_s) begin
          resp_d  = {HDR_CMD, OP_RSP, cmd_tag_s, cmd_addr_s, rd_val_s};
          state_d = ST_RESP;
        end else begin
          resp_d  = {HDR_CMD, OP_ERR, cmd_tag_s, cmd_addr_s, 64'd0};
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (dma2um_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Ready is registered so it stays low throughout reset and rises on the
    // first edge after release.
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      cmd_q      <= 96'd0;
      resp_q     <= 134'd0;
      ptype_q    <= 8'd0;
      rtt_q      <= 32'd0;
      stat_rst_q <= 1'b0;
      drop_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      cmd_q      <= cmd_d;
      resp_q     <= resp_d;
      ptype_q    <= ptype_d;
      rtt_q      <= rtt_d;
      stat_rst_q <= stat_rst_d;
      drop_q     <= drop_d;
    end
  end

  assign um2dma_ready      = ready_q;
  assign um2dma_data       = resp_q;
  // The strobe marks the handshake cycle itself, so it follows the sink's
  // ready combinationally while a response is held.
  assign um2dma_data_wr    = (state_q == ST_RESP) && dma2um_ready;
  assign cfg_protocol_type = ptype_q;
  assign cfg_n_rtt         = rtt_q;
  assign cfg_stat_reset    = stat_rst_q;

endmodule

// File: tb/tb_um_cfg_ctrl.sv
// Testbench for um_cfg_ctrl: directed vector table, reset corner sequences and
// randomized commands checked against a register-map reference model.
module tb_um_cfg_ctrl;

  localparam logic [31:0] BASE = 32'h7000_0000;
  localparam logic [63:0] SB = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SP = 64'h1111_2222_3333_4444;
  localparam logic [63:0] ST = 64'hFEDC_BA98_7654_3210;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [133:0] dma2um_data;
  logic         dma2um_data_wr;
  logic         um2dma_ready;
  logic [133:0] um2dma_data;
  logic         um2dma_data_wr;
  logic         dma2um_ready;
  logic [7:0]   cfg_protocol_type;
  logic         cfg_stat_reset;
  logic [31:0]  cfg_n_rtt;
  logic [63:0]  stat_bit_cnt;
  logic [63:0]  stat_pkt_cnt;
  logic [63:0]  stat_time_cnt;

  int total = 0;
  int bad = 0;

  // Reference model state.
  logic [7:0]  m_ptype;
  logic [31:0] m_rtt;
  int          m_drop;

  always #5 clk = ~clk;

  um_cfg_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .dma2um_data(dma2um_data), .dma2um_data_wr(dma2um_data_wr),
    .um2dma_ready(um2dma_ready), .um2dma_data(um2dma_data),
    .um2dma_data_wr(um2dma_data_wr), .dma2um_ready(dma2um_ready),
    .cfg_protocol_type(cfg_protocol_type), .cfg_stat_reset(cfg_stat_reset),
    .cfg_n_rtt(cfg_n_rtt), .stat_bit_cnt(stat_bit_cnt),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_time_cnt(stat_time_cnt)
  );

  typedef struct {
    string       name;
    logic [5:0]  hdr;
    logic [7:0]  op;
    logic [23:0] tag;
    logic [31:0] addr;
    logic [63:0] data;
    int          stall;
    logic [7:0]  eop;    // 00 = accepted write, FF = dropped, else response opcode
    logic [63:0] edata;  // response data, or written value for writes
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  function automatic logic [133:0] mk(input logic [5:0] h, input logic [7:0] op,
                                      input logic [23:0] tag, input logic [31:0] a,
                                      input logic [63:0] d);
    return {h, op, tag, a, d};
  endfunction

  // Expected outcome of a command from the register map rules.
  function automatic void model_eval(input logic [133:0] f, output logic [7:0] eop,
                                     output logic [63:0] edata);
    logic [7:0]  op;
    logic [31:0] a;
    logic [63:0] d;
    bit          in_win;
    int          off;
    op = f[127:120];
    a = f[95:64];
    d = f[63:0];
    in_win = (a >= BASE) && ((a - BASE) < 32'd20);
    off = int'(a - BASE);
    eop = 8'hE0;
    edata = 64'd0;
    if (f[133:128] != 6'b010000) begin
      eop = 8'hFF;
    end else if (in_win && op == 8'hA0 && off <= 2) begin
      eop = 8'h00;
      if (off == 0) edata = {56'd0, d[7:0]};
      else if (off == 1) edata = {63'd0, d[0]};
      else edata = {32'd0, d[31:0]};
    end else if (in_win && op == 8'hB0) begin
      case (off)
        0:  begin eop = 8'hC0; edata = {56'd0, m_ptype}; end
        2:  begin eop = 8'hC0; edata = {32'd0, m_rtt}; end
        16: begin eop = 8'hC0; edata = stat_bit_cnt; end
        17: begin eop = 8'hC0; edata = stat_pkt_cnt; end
        18: begin eop = 8'hC0; edata = stat_time_cnt; end
        19: begin eop = 8'hC0; edata = {48'd0, 16'(m_drop)}; end
        default: begin eop = 8'hE0; edata = 64'd0; end
      endcase
    end
  endfunction

  task automatic model_reset();
    m_ptype = 8'd0;
    m_rtt = 32'd0;
    m_drop = 0;
  endtask

  // Issue one command and check the full handshake against the expectation.
  task automatic do_cmd(input logic [133:0] f, input int stall, input logic [7:0] eop,
                        input logic [63:0] ed, input string name);
    int w;
    int off;
    logic [133:0] exp_f;
    logic [63:0] sb, sp, st;
    off = int'(f[95:64] - BASE);
    exp_f = {6'b010000, eop, f[119:96], f[95:64], ed};
    w = 0;
    nxt();
    while (!um2dma_ready && w < 8) begin
      dma2um_data_wr = 1'b0;
      w++;
      nxt();
    end
    chk({name, "_rdy_in"}, 134'(um2dma_ready), 134'(1'b1));
    // acceptance cycle
    dma2um_data_wr = 1'b1;
    dma2um_data = f;
    dma2um_ready = 1'($urandom);
    #1;
    chk({name, "_stb_acc"}, 134'(um2dma_data_wr), 134'(1'b0));
    nxt();
    if (eop == 8'hFF) begin
      dma2um_data_wr = 1'b0;
      #1;
      if (m_drop < 65535) m_drop = m_drop + 1;
      chk({name, "_drop_rdy"}, 134'(um2dma_ready), 134'(1'b1));
      return;
    end
    // EXEC cycle; junk flits must be ignored
    dma2um_data_wr = 1'($urandom);
    dma2um_data = 134'({$urandom, $urandom, $urandom, $urandom, $urandom});
    dma2um_ready = 1'($urandom);
    #1;
    chk({name, "_exec_rdy"}, 134'(um2dma_ready), 134'(1'b0));
    chk({name, "_exec_stb"}, 134'(um2dma_data_wr), 134'(1'b0));
    chk({name, "_exec_pulse"}, 134'(cfg_stat_reset), 134'(1'b0));
    if (eop == 8'h00) begin
      nxt();
      dma2um_data_wr = 1'b0;
      dma2um_ready = 1'($urandom);
      #1;
      if (off == 0) m_ptype = f[7:0];
      if (off == 2) m_rtt = f[31:0];
      chk({name, "_wr_rdy"}, 134'(um2dma_ready), 134'(1'b1));
      chk({name, "_wr_stb"}, 134'(um2dma_data_wr), 134'(1'b0));
      chk({name, "_ptype"}, 134'(cfg_protocol_type), 134'(m_ptype));
      chk({name, "_rtt"}, 134'(cfg_n_rtt), 134'(m_rtt));
      chk({name, "_pulse"}, 134'(cfg_stat_reset), 134'((off == 1) ? ed[0] : 1'b0));
      case (off)
        0: chk({name, "_tgt"}, 134'(cfg_protocol_type), 134'(ed[7:0]));
        2: chk({name, "_tgt"}, 134'(cfg_n_rtt), 134'(ed[31:0]));
        default: ;
      endcase
      nxt();
      #1;
      chk({name, "_pulse_end"}, 134'(cfg_stat_reset), 134'(1'b0));
    end else begin
      sb = stat_bit_cnt;
      sp = stat_pkt_cnt;
      st = stat_time_cnt;
      for (int k = 0; k <= stall; k++) begin
        nxt();
        dma2um_data_wr = 1'($urandom);
        dma2um_data = 134'({$urandom, $urandom, $urandom, $urandom, $urandom});
        dma2um_ready = (k == stall);
        stat_bit_cnt = {$urandom, $urandom};
        stat_pkt_cnt = {$urandom, $urandom};
        stat_time_cnt = {$urandom, $urandom};
        #1;
        chk({name, "_resp_rdy"}, 134'(um2dma_ready), 134'(1'b0));
        chk({name, "_resp_data"}, um2dma_data, exp_f);
        chk({name, "_resp_stb"}, 134'(um2dma_data_wr), 134'(k == stall));
      end
      nxt();
      dma2um_data_wr = 1'b0;
      dma2um_ready = 1'($urandom);
      stat_bit_cnt = sb;
      stat_pkt_cnt = sp;
      stat_time_cnt = st;
      #1;
      chk({name, "_post_rdy"}, 134'(um2dma_ready), 134'(1'b1));
      chk({name, "_post_stb"}, 134'(um2dma_data_wr), 134'(1'b0));
      chk({name, "_post_ptype"}, 134'(cfg_protocol_type), 134'(m_ptype));
      chk({name, "_post_rtt"}, 134'(cfg_n_rtt), 134'(m_rtt));
    end
  endtask

  // Main stimulus: reset, directed table, reset corners, random commands.
  initial begin
    logic [7:0]  eop;
    logic [63:0] ed;
    rst_n = 1'b0;
    dma2um_data_wr = 1'b1;
    dma2um_data = mk(6'b010000, 8'hB0, 24'h1, BASE, 64'd0);
    dma2um_ready = 1'b1;
    stat_bit_cnt = SB;
    stat_pkt_cnt = SP;
    stat_time_cnt = ST;
    model_reset();

    repeat (3) nxt();
    #1;
    chk("rst_ready", 134'(um2dma_ready), 134'(1'b0));
    chk("rst_stb", 134'(um2dma_data_wr), 134'(1'b0));
    chk("rst_data", um2dma_data, 134'd0);
    chk("rst_ptype", 134'(cfg_protocol_type), 134'd0);
    chk("rst_rtt", 134'(cfg_n_rtt), 134'd0);
    chk("rst_pulse", 134'(cfg_stat_reset), 134'd0);
    nxt();
    rst_n = 1'b1;
    dma2um_data_wr = 1'b0;
    #1;
    nxt();
    #1;
    chk("ready_after_release", 134'(um2dma_ready), 134'(1'b1));

    tbl.push_back('{"wr_ptype",    6'h10, 8'hA0, 24'h000001, 32'h7000_0000, 64'h82, 0, 8'h00, 64'h82});
    tbl.push_back('{"wr_rtt",      6'h10, 8'hA0, 24'h000002, 32'h7000_0002, 64'h30, 0, 8'h00, 64'h30});
    tbl.push_back('{"rd_rtt",      6'h10, 8'hB0, 24'h008007, 32'h7000_0002, 64'h0, 0, 8'hC0, 64'h30});
    tbl.push_back('{"pulse1",      6'h10, 8'hA0, 24'h000003, 32'h7000_0001, 64'h1, 0, 8'h00, 64'h1});
    tbl.push_back('{"pulse0",      6'h10, 8'hA0, 24'h000004, 32'h7000_0001, 64'h0, 0, 8'h00, 64'h0});
    tbl.push_back('{"rd_pkt_stall",6'h10, 8'hB0, 24'h000005, 32'h7000_0011, 64'h0, 5, 8'hC0, SP});
    tbl.push_back('{"drop_hdr",    6'h20, 8'hB0, 24'h000006, 32'h7000_0013, 64'h0, 0, 8'hFF, 64'h0});
    tbl.push_back('{"rd_drop",     6'h10, 8'hB0, 24'h000007, 32'h7000_0013, 64'h0, 1, 8'hC0, 64'h1});
    tbl.push_back('{"bad_op",      6'h10, 8'h55, 24'h000008, 32'h7000_0000, 64'hDEAD, 2, 8'hE0, 64'h0});
    tbl.push_back('{"rd_ptype",    6'h10, 8'hB0, 24'h000009, 32'h7000_0000, 64'h0, 0, 8'hC0, 64'h82});
    tbl.push_back('{"rd_off1",     6'h10, 8'hB0, 24'h00000A, 32'h7000_0001, 64'h0, 0, 8'hE0, 64'h0});
    tbl.push_back('{"wr_ro",       6'h10, 8'hA0, 24'h00000B, 32'h7000_0010, 64'h55, 0, 8'hE0, 64'h0});
    tbl.push_back('{"rd_outside",  6'h10, 8'hB0, 24'h00000C, 32'h7000_0014, 64'h0, 0, 8'hE0, 64'h0});
    tbl.push_back('{"rd_below",    6'h10, 8'hB0, 24'h00000D, 32'h6FFF_FFFF, 64'h0, 0, 8'hE0, 64'h0});
    tbl.push_back('{"rd_bit",      6'h10, 8'hB0, 24'h00000E, 32'h7000_0010, 64'h0, 0, 8'hC0, SB});
    tbl.push_back('{"rd_time",     6'h10, 8'hB0, 24'h00000F, 32'h7000_0012, 64'h0, 3, 8'hC0, ST});
    tbl.push_back('{"wr_ptype_hi", 6'h10, 8'hA0, 24'h000010, 32'h7000_0000, 64'hFFFF_FFFF_FFFF_FF5A, 0, 8'h00, 64'h5A});

    foreach (tbl[i]) begin
      do_cmd(mk(tbl[i].hdr, tbl[i].op, tbl[i].tag, tbl[i].addr, tbl[i].data),
             tbl[i].stall, tbl[i].eop, tbl[i].edata, tbl[i].name);
    end

    // Reset while a read response is being held.
    nxt();
    dma2um_data_wr = 1'b1;
    dma2um_data = mk(6'b010000, 8'hB0, 24'h0000AA, 32'h7000_0000, 64'd0);
    dma2um_ready = 1'b0;
    #1;
    nxt();
    dma2um_data_wr = 1'b0;
    #1;
    nxt();
    #1;
    chk("rresp_in_resp_rdy", 134'(um2dma_ready), 134'(1'b0));
    nxt();
    rst_n = 1'b0;
    #1;
    nxt();
    dma2um_ready = 1'b1;
    #1;
    chk("rresp_stb", 134'(um2dma_data_wr), 134'(1'b0));
    chk("rresp_data", um2dma_data, 134'd0);
    chk("rresp_ptype", 134'(cfg_protocol_type), 134'd0);
    chk("rresp_rtt", 134'(cfg_n_rtt), 134'd0);
    chk("rresp_rdy_low", 134'(um2dma_ready), 134'(1'b0));
    nxt();
    rst_n = 1'b1;
    #1;
    nxt();
    #1;
    chk("rresp_rdy_release", 134'(um2dma_ready), 134'(1'b1));
    for (int k = 0; k < 3; k++) begin
      nxt();
      #1;
      chk("rresp_no_late_stb", 134'(um2dma_data_wr), 134'(1'b0));
    end
    model_reset();

    // Reset while a write is executing discards it.
    nxt();
    dma2um_data_wr = 1'b1;
    dma2um_data = mk(6'b010000, 8'hA0, 24'h0000BB, 32'h7000_0000, 64'h77);
    #1;
    nxt();
    dma2um_data_wr = 1'b0;
    rst_n = 1'b0;
    #1;
    nxt();
    rst_n = 1'b1;
    #1;
    chk("rexec_ptype", 134'(cfg_protocol_type), 134'd0);
    nxt();
    #1;
    chk("rexec_rdy", 134'(um2dma_ready), 134'(1'b1));
    chk("rexec_ptype_after", 134'(cfg_protocol_type), 134'd0);
    chk("rexec_drop_cleared_stb", 134'(um2dma_data_wr), 134'(1'b0));

    // Randomized commands against the model.
    for (int i = 0; i < 150; i++) begin
      logic [5:0]  h;
      logic [7:0]  op;
      logic [31:0] a;
      logic [133:0] f;
      stat_bit_cnt = {$urandom, $urandom};
      stat_pkt_cnt = {$urandom, $urandom};
      stat_time_cnt = {$urandom, $urandom};
      h = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'b010000;
      case ($urandom_range(0, 3))
        0: op = 8'hA0;
        1, 2: op = 8'hB0;
        default: op = 8'($urandom);
      endcase
      a = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'($urandom_range(0, 23));
      f = mk(h, op, 24'($urandom), a, {$urandom, $urandom});
      model_eval(f, eop, ed);
      do_cmd(f, $urandom_range(0, 3), eop, ed, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
